// File: rtl/arch_dump_pkg.sv
// rtl/arch_dump_pkg.sv - shared types and constants for the architectural register dumper
package arch_dump_pkg;

  localparam int DFLT_ARCH_REGS = 32;
  localparam int DFLT_PREG_W    = 7;
  localparam int DFLT_XLEN      = 32;

  localparam int REG_A0 = 10;
  localparam int REG_A1 = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_SCAN,
    ST_MAP,
    ST_PRF,
    ST_EMIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [$clog2(DFLT_ARCH_REGS)-1:0] arch;
    logic [DFLT_PREG_W-1:0]            preg;
    logic [DFLT_XLEN-1:0]              value;
  } dump_rec_t;

endpackage

// File: rtl/lowest_set_bit_enc.sv
// rtl/lowest_set_bit_enc.sv - priority encoder returning the index of the lowest set bit
module lowest_set_bit_enc #(
  parameter int W     = 32,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arch_reg_dumper.sv
// rtl/arch_reg_dumper.sv - waits for commit quiescence, then streams mask-selected
// architectural registers as {arch, preg, value} records via rename map and PRF reads.
module arch_reg_dumper
  import arch_dump_pkg::*;
#(
  parameter int ARCH_REGS      = DFLT_ARCH_REGS,
  parameter int PREG_W         = DFLT_PREG_W,
  parameter int XLEN           = DFLT_XLEN,
  parameter int COMMIT_W       = 2,
  parameter int QUIESCE_CYCLES = 16,
  parameter int WDOG_W         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         force_en,
  input  logic [ARCH_REGS-1:0]         reg_mask,
  input  logic [WDOG_W-1:0]            wdog_limit,
  input  logic [COMMIT_W-1:0]          commit_valid,
  output logic [$clog2(ARCH_REGS)-1:0] map_rd_addr,
  input  logic [PREG_W-1:0]            map_rd_data,
  output logic [PREG_W-1:0]            prf_rd_addr,
  input  logic [XLEN-1:0]              prf_rd_data,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic [$clog2(ARCH_REGS)-1:0] dump_arch,
  output logic [PREG_W-1:0]            dump_preg,
  output logic [XLEN-1:0]              dump_value,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout
);

  localparam int AW = $clog2(ARCH_REGS);
  localparam int QW = $clog2(QUIESCE_CYCLES + 1);
  localparam logic [QW-1:0] QMAX = QW'(QUIESCE_CYCLES);

  state_t                state, state_nx;
  logic [ARCH_REGS-1:0]  mask_q;
  logic [QW-1:0]         quiet_q;
  logic [WDOG_W-1:0]     wdog_q;
  logic [WDOG_W-1:0]     wdog_inc;
  logic                  wdog_hit;
  logic                  timeout_q;
  logic [AW-1:0]         map_addr_q;
  logic [AW-1:0]         enc_idx;
  logic                  enc_any;
  logic [PREG_W-1:0]     prf_addr_q;
  logic [XLEN-1:0]       value_q;

  lowest_set_bit_enc #(
    .W     (ARCH_REGS),
    .IDX_W (AW)
  ) u_enc (
    .mask (mask_q),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // The watchdog counts the current QUIESCE cycle, so QUIESCE lasts at most wdog_limit cycles.
  assign wdog_inc = wdog_q + WDOG_W'(1);
  assign wdog_hit = (wdog_limit != '0) && (wdog_inc == wdog_limit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Read addresses are presented combinationally in the cycle before their data is needed.
  always_comb begin
    state_nx    = state;
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    dump_valid  = (state == ST_EMIT);
    map_rd_addr = map_addr_q;
    prf_rd_addr = prf_addr_q;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = force_en ? ST_SCAN : ST_QUIESCE;
      end
      ST_QUIESCE: begin
        if ((quiet_q == QMAX) || wdog_hit) state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        if (enc_any) begin
          map_rd_addr = enc_idx;
          state_nx    = ST_MAP;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_MAP: begin
        prf_rd_addr = map_rd_data;
        state_nx    = ST_PRF;
      end
      ST_PRF:  state_nx = ST_EMIT;
      ST_EMIT: begin
        if (dump_ready) state_nx = ST_SCAN;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q     <= '0;
      quiet_q    <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
      map_addr_q <= '0;
      prf_addr_q <= '0;
      value_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q    <= reg_mask;
            quiet_q   <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_QUIESCE: begin
          if (|commit_valid) begin
            quiet_q <= '0;
          end else if (quiet_q != QMAX) begin
            quiet_q <= quiet_q + QW'(1);
          end
          wdog_q <= wdog_inc;
          if (wdog_hit) timeout_q <= 1'b1;
        end
        ST_SCAN: begin
          if (enc_any) begin
            mask_q[enc_idx] <= 1'b0;
            map_addr_q      <= enc_idx;
          end
        end
        ST_MAP: prf_addr_q <= map_rd_data;
        ST_PRF: value_q    <= prf_rd_data;
        default: ;
      endcase
    end
  end

  // The held read addresses double as the record payload while in EMIT.
  assign dump_arch  = map_addr_q;
  assign dump_preg  = prf_addr_q;
  assign dump_value = value_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_arch_reg_dumper.sv
// tb/tb_arch_reg_dumper.sv - directed self-checking bench for arch_reg_dumper
module tb_arch_reg_dumper;
  import arch_dump_pkg::*;

  localparam int AR = 32;
  localparam int PW = 7;
  localparam int XL = 32;
  localparam int CW = 2;
  localparam int QC = 16;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          force_en = 1'b0;
  logic [AR-1:0] reg_mask = '0;
  logic [WW-1:0] wdog_limit = '0;
  logic [CW-1:0] commit_valid = '0;
  logic [4:0]    map_rd_addr;
  logic [PW-1:0] map_rd_data = '0;
  logic [PW-1:0] prf_rd_addr;
  logic [XL-1:0] prf_rd_data = '0;
  logic          dump_valid;
  logic          dump_ready = 1'b1;
  logic [4:0]    dump_arch;
  logic [PW-1:0] dump_preg;
  logic [XL-1:0] dump_value;
  logic          busy;
  logic          done;
  logic          timeout;

  logic [PW-1:0] map_mem [AR];
  logic [XL-1:0] prf_mem [128];
  dump_rec_t     rec_q [$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  arch_reg_dumper #(
    .ARCH_REGS      (AR),
    .PREG_W         (PW),
    .XLEN           (XL),
    .COMMIT_W       (CW),
    .QUIESCE_CYCLES (QC),
    .WDOG_W         (WW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .force_en     (force_en),
    .reg_mask     (reg_mask),
    .wdog_limit   (wdog_limit),
    .commit_valid (commit_valid),
    .map_rd_addr  (map_rd_addr),
    .map_rd_data  (map_rd_data),
    .prf_rd_addr  (prf_rd_addr),
    .prf_rd_data  (prf_rd_data),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_arch    (dump_arch),
    .dump_preg    (dump_preg),
    .dump_value   (dump_value),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
  );

  // Synchronous-read rename map and PRF with one cycle of read latency.
  always @(posedge clk) begin
    map_rd_data <= map_mem[map_rd_addr];
    prf_rd_data <= prf_mem[prf_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [AR-1:0] mask, input logic frc);
    reg_mask = mask;
    force_en = frc;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  function automatic dump_rec_t exp_rec(input int a);
    dump_rec_t r;
    r.arch  = 5'(a);
    r.preg  = 7'(3 * a + 7);
    r.value = prf_mem[3 * a + 7];
    return r;
  endfunction

  task automatic collect(input int limit, input bit rnd);
    dump_rec_t held_rec;
    bit        held;
    bit        got_done;
    int        fire_c;
    int        done_c;
    held     = 1'b0;
    got_done = 1'b0;
    fire_c   = -1;
    done_c   = -1;
    held_rec = '0;
    rec_q.delete();
    for (int c = 0; c < limit && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
        done_c   = c;
      end else begin
        dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dump_valid) begin
          if (held) check("stall_stable", 64'({dump_arch, dump_preg, dump_value}), 64'(held_rec));
          if (dump_ready) begin
            rec_q.push_back('{dump_arch, dump_preg, dump_value});
            held   = 1'b0;
            fire_c = c;
          end else begin
            held     = 1'b1;
            held_rec = '{dump_arch, dump_preg, dump_value};
          end
        end
        tick();
      end
    end
    check("walk_done", 64'(got_done), 64'd1);
    if (got_done && fire_c >= 0) check("done_lat", 64'(done_c - fire_c), 64'd2);
    tick();
    check("done_pulse", 64'(done), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    dump_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < AR; i++) map_mem[i] = 7'(3 * i + 7);
    for (int p = 0; p < 128; p++) prf_mem[p] = 32'hA5A5_0000 ^ (32'(p) * 32'h0001_0101);
    prf_mem[37] = 32'h0000_002A;
    prf_mem[40] = 32'hFFFF_FFFF;

    // Reset state
    repeat (3) tick();
    check("rst_valid", 64'(dump_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_addrs", 64'({map_rd_addr, prf_rd_addr}), 64'd0);
    check("rst_payload", 64'({dump_arch, dump_preg, dump_value}), 64'd0);
    reset = 1'b1;
    tick();

    // a0/a1 forced dump with fixed 3-cycle latency
    start_dump(32'h0000_0C00, 1'b1);
    check("t1_scan_addr", 64'(map_rd_addr), 64'd10);
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_prf_addr", 64'(prf_rd_addr), 64'd37);
    tick();
    check("t1_prf_novalid", 64'(dump_valid), 64'd0);
    tick();
    check("t1_valid", 64'(dump_valid), 64'd1);
    check("t1_rec0", 64'({dump_arch, dump_preg, dump_value}), {5'd10, 7'd37, 32'h0000_002A});
    collect(50, 1'b0);
    check("t1_count", 64'(rec_q.size()), 64'd2);
    if (rec_q.size() == 2)
      check("t1_rec1", 64'(rec_q[1]), {5'd11, 7'd40, 32'hFFFF_FFFF});

    // Quiesce: commits every 5 cycles, walk begins 17 cycles after the last one
    start_dump(32'h0000_0020, 1'b0);
    for (int c = 0; c < 40; c++) begin
      commit_valid = (c % 5 == 0) ? 2'b01 : 2'b00;
      tick();
    end
    commit_valid = 2'b00;
    repeat (12) tick();
    check("t2_still_quiet", 64'({busy, map_rd_addr}), {58'd0, 1'b1, 5'd11});
    tick();
    check("t2_first_map", 64'(map_rd_addr), 64'd5);
    check("t2_timeout", 64'(timeout), 64'd0);
    collect(50, 1'b0);
    check("t2_count", 64'(rec_q.size()), 64'd1);
    if (rec_q.size() == 1) check("t2_rec", 64'(rec_q[0]), 64'(exp_rec(5)));

    // Watchdog under continuous commits
    commit_valid = 2'b11;
    wdog_limit   = 16'd20;
    start_dump(AR'((1 << REG_A0) | (1 << REG_A1)), 1'b0);
    repeat (19) tick();
    check("t3_pre_timeout", 64'({busy, timeout}), 64'b10);
    tick();
    check("t3_timeout", 64'(timeout), 64'd1);
    check("t3_scan_addr", 64'(map_rd_addr), 64'(REG_A0));
    collect(50, 1'b0);
    check("t3_count", 64'(rec_q.size()), 64'd2);
    check("t3_sticky", 64'(timeout), 64'd1);
    commit_valid = 2'b00;
    wdog_limit   = '0;

    // Full mask, random backpressure; start clears timeout
    start_dump('1, 1'b1);
    check("t4_timeout_clr", 64'(timeout), 64'd0);
    collect(2000, 1'b1);
    check("t4_count", 64'(rec_q.size()), 64'd32);
    for (int i = 0; i < 32 && i < rec_q.size(); i++)
      check($sformatf("t4_rec%0d", i), 64'(rec_q[i]), 64'(exp_rec(i)));

    // Empty mask
    start_dump('0, 1'b1);
    collect(20, 1'b0);
    check("t5_empty", 64'(rec_q.size()), 64'd0);

    // start while busy is ignored
    start_dump(32'h0000_0008, 1'b1);
    reg_mask = '1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    collect(50, 1'b0);
    check("t5_ign_count", 64'(rec_q.size()), 64'd1);
    if (rec_q.size() == 1) check("t5_ign_rec", 64'(rec_q[0]), 64'(exp_rec(3)));

    // Reset during EMIT
    dump_ready = 1'b0;
    start_dump(32'h0000_0006, 1'b1);
    repeat (3) tick();
    check("t6_in_emit", 64'(dump_valid), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_abort", 64'({dump_valid, busy, done}), 64'd0);
    check("t6_payload", 64'({dump_arch, dump_preg, dump_value}), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_done", 64'({done, busy}), 64'd0);
    end
    dump_ready = 1'b1;
    start_dump(32'h0000_0080, 1'b1);
    collect(50, 1'b0);
    check("t6_count", 64'(rec_q.size()), 64'd1);
    if (rec_q.size() == 1) check("t6_rec", 64'(rec_q[0]), 64'(exp_rec(7)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
